// File: rtl/arb_pkg.sv
// Shared constants and channel helpers for the 3-way round-robin arbiter family.
// Channel numbering matches the select encoding of the downstream 3:1 mux.
package arb_pkg;

   localparam int SEL_WIDTH = 2;
   localparam int N_CH      = 3;

   typedef logic [SEL_WIDTH-1:0] sel_t;

   localparam sel_t CH_0 = 2'd0;
   localparam sel_t CH_1 = 2'd1;
   localparam sel_t CH_2 = 2'd2;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   // Mod-3 successor; an illegal 3 folds back to channel 0.
   function automatic sel_t next_ch(input sel_t ch);
      case (ch)
         CH_0:    next_ch = CH_1;
         CH_1:    next_ch = CH_2;
         default: next_ch = CH_0;
      endcase
   endfunction

   function automatic logic ch_bit(input logic [N_CH-1:0] vec, input sel_t ch);
      case (ch)
         CH_0:    ch_bit = vec[0];
         CH_1:    ch_bit = vec[1];
         CH_2:    ch_bit = vec[2];
         default: ch_bit = 1'b0;
      endcase
   endfunction

   function automatic logic [N_CH-1:0] ch_onehot(input sel_t ch);
      case (ch)
         CH_0:    ch_onehot = 3'b001;
         CH_1:    ch_onehot = 3'b010;
         CH_2:    ch_onehot = 3'b100;
         default: ch_onehot = 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/rr_pick_3.sv
// Combinational round-robin search over three requesters, starting at ptr_i.
// Reusable by any 3-way arbiter; found_o is low when no request is present.
module rr_pick_3
   import arb_pkg::*;
(
   input  logic [N_CH-1:0] req_i,
   input  sel_t            ptr_i,
   output sel_t            idx_o,
   output logic            found_o
);

   sel_t cand1;
   sel_t cand2;

   // Priority search in the order ptr, ptr+1, ptr+2 (mod 3).
   always_comb begin
      cand1   = next_ch(ptr_i);
      cand2   = next_ch(cand1);
      idx_o   = ptr_i;
      found_o = 1'b0;
      if (ch_bit(req_i, ptr_i)) begin
         idx_o   = ptr_i;
         found_o = 1'b1;
      end else if (ch_bit(req_i, cand1)) begin
         idx_o   = cand1;
         found_o = 1'b1;
      end else if (ch_bit(req_i, cand2)) begin
         idx_o   = cand2;
         found_o = 1'b1;
      end else begin
         idx_o   = ptr_i;
         found_o = 1'b0;
      end
   end

endmodule

// File: rtl/rr_arb_3.sv
// Three-channel round-robin packet arbiter driving the select of an external 3:1 mux.
// Holds a grant until the packet's last beat (or the beat watchdog), then rotates priority.
module rr_arb_3
   import arb_pkg::*;
#(
   parameter int MAX_BEATS = 16,
   parameter bit LOCK_EN   = 1'b1,
   parameter int CNT_WIDTH = $clog2(MAX_BEATS + 1)
) (
   input  logic            clk_i,
   input  logic            s_rst_n_i,
   input  logic [N_CH-1:0] valid_i,
   input  logic [N_CH-1:0] last_i,
   output logic [N_CH-1:0] ready_o,
   input  logic            ready_i,
   output logic            valid_o,
   output sel_t            select_o,
   output logic            busy_o,
   output logic            err_o
);

   logic [0:0]           state_q, state_d;
   sel_t                 ptr_q, ptr_d;
   sel_t                 sel_q, sel_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 err_q, err_d;

   sel_t pick_idx;
   logic pick_found;
   logic granted;
   logic xfer;
   logic is_last;
   logic wd_hit;

   rr_pick_3 u_pick (
      .req_i   (valid_i),
      .ptr_i   (ptr_q),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   // Downstream handshake only ever looks at registered grant state, so ready_i never reaches valid_o.
   assign granted  = (state_q == ST_GRANT);
   assign valid_o  = granted & ch_bit(valid_i, sel_q);
   assign ready_o  = granted ? (ch_onehot(sel_q) & {N_CH{ready_i}}) : 3'b000;
   assign xfer     = valid_o & ready_i;
   assign is_last  = LOCK_EN ? ch_bit(last_i, sel_q) : 1'b1;
   assign wd_hit   = (cnt_q == CNT_WIDTH'(MAX_BEATS - 1));
   assign select_o = sel_q;
   assign busy_o   = granted;
   assign err_o    = err_q;

   // Next-state: arbitrate in IDLE, count beats and decide release in GRANT.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               sel_d   = pick_idx;
               state_d = ST_GRANT;
            end else begin
               sel_d   = sel_q;
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (xfer && (is_last || wd_hit)) begin
               state_d = ST_IDLE;
               ptr_d   = next_ch(sel_q);
               cnt_d   = '0;
               err_d   = ~is_last;
            end else if (xfer) begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!s_rst_n_i) begin
         state_q <= ST_IDLE;
         ptr_q   <= CH_0;
         sel_q   <= CH_0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_rr_arb_3.sv
// Directed bench for rr_arb_3: a locked instance with a short watchdog and
// a per-beat (LOCK_EN=0) instance, both checked against hand-computed values.
module tb_rr_arb_3;

   logic       clk;
   logic       rst_n;
   logic [2:0] va, la, rdy_a;
   logic       ri_a;
   logic       vo_a, busy_a, err_a;
   logic [1:0] sel_a;
   logic [2:0] vb, lb, rdy_b;
   logic       ri_b;
   logic       vo_b, busy_b, err_b;
   logic [1:0] sel_b;

   int n_tests = 0;
   int n_fail  = 0;

   rr_arb_3 #(.MAX_BEATS(4), .LOCK_EN(1'b1)) dut_a (
      .clk_i(clk), .s_rst_n_i(rst_n), .valid_i(va), .last_i(la), .ready_o(rdy_a),
      .ready_i(ri_a), .valid_o(vo_a), .select_o(sel_a), .busy_o(busy_a), .err_o(err_a)
   );

   rr_arb_3 #(.MAX_BEATS(16), .LOCK_EN(1'b0)) dut_b (
      .clk_i(clk), .s_rst_n_i(rst_n), .valid_i(vb), .last_i(lb), .ready_o(rdy_b),
      .ready_i(ri_b), .valid_o(vo_b), .select_o(sel_b), .busy_o(busy_b), .err_o(err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] v, input logic [2:0] l, input logic r);
      va   = v;
      la   = l;
      ri_a = r;
      #1;
   endtask

   initial begin
      logic [1:0] order2 [5];
      logic [1:0] order6 [4];
      logic       bp [4];
      order2 = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
      order6 = '{2'd0, 2'd2, 2'd0, 2'd2};
      bp     = '{1'b1, 1'b0, 1'b0, 1'b1};

      rst_n = 1'b0;
      va = 3'b000; la = 3'b000; ri_a = 1'b0;
      vb = 3'b000; lb = 3'b000; ri_b = 1'b0;
      cyc(); cyc();
      chk("rst_busy",  {3'b000, busy_a}, 4'h0);
      chk("rst_sel",   {2'b00, sel_a},   4'h0);
      chk("rst_valid", {3'b000, vo_a},   4'h0);
      chk("rst_ready", {1'b0, rdy_a},    4'h0);
      chk("rst_err",   {3'b000, err_a},  4'h0);
      chk("rst_b_busy", {3'b000, busy_b}, 4'h0);
      rst_n = 1'b1;

      // Single channel 1, three-beat packet
      drive(3'b010, 3'b000, 1'b1);
      cyc();
      chk("t1_sel",   {2'b00, sel_a},   4'h1);
      chk("t1_busy",  {3'b000, busy_a}, 4'h1);
      chk("t1_valid", {3'b000, vo_a},   4'h1);
      chk("t1_ready", {1'b0, rdy_a},    4'h2);
      cyc();
      chk("t1_b2_ready", {1'b0, rdy_a}, 4'h2);
      cyc();
      drive(3'b010, 3'b010, 1'b1);
      chk("t1_b3_ready", {1'b0, rdy_a}, 4'h2);
      cyc();
      drive(3'b000, 3'b000, 1'b1);
      chk("t1_rel_busy",  {3'b000, busy_a}, 4'h0);
      chk("t1_rel_ready", {1'b0, rdy_a},    4'h0);
      chk("t1_rel_err",   {3'b000, err_a},  4'h0);
      chk("t1_rel_hold",  {2'b00, sel_a},   4'h1);
      // ptr must now be 2: all channels requesting picks channel 2
      drive(3'b111, 3'b111, 1'b1);
      cyc();
      chk("t1_ptr2", {2'b00, sel_a}, 4'h2);
      cyc();
      drive(3'b000, 3'b000, 1'b0);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;

      // All request, one-beat packets
      drive(3'b111, 3'b111, 1'b1);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("t2_grant", {2'b00, sel_a},   {2'b00, order2[k]});
         chk("t2_busy",  {3'b000, busy_a}, 4'h1);
         chk("t2_ready", {1'b0, rdy_a},    {1'b0, 3'b001 << order2[k]});
         cyc();
         chk("t2_bubble",       {3'b000, busy_a}, 4'h0);
         chk("t2_bubble_valid", {3'b000, vo_a},   4'h0);
         chk("t2_hold",         {2'b00, sel_a},   {2'b00, order2[k]});
      end

      // Backpressure on channel 0 while channel 1 also requests (ptr=2)
      drive(3'b011, 3'b000, 1'b1);
      cyc();
      chk("t3_sel", {2'b00, sel_a}, 4'h0);
      for (int i = 0; i < 4; i++) begin
         drive(3'b011, 3'b000, bp[i]);
         chk("t3_ready", {1'b0, rdy_a},    {3'b000, bp[i]});
         chk("t3_hold",  {2'b00, sel_a},   4'h0);
         chk("t3_busy",  {3'b000, busy_a}, 4'h1);
         cyc();
      end
      drive(3'b011, 3'b001, 1'b1);
      chk("t3_last_ready", {1'b0, rdy_a}, 4'h1);
      cyc();
      chk("t3_rel_busy", {3'b000, busy_a}, 4'h0);
      chk("t3_rel_err",  {3'b000, err_a},  4'h0);
      drive(3'b011, 3'b010, 1'b1);
      cyc();
      chk("t3_next", {2'b00, sel_a}, 4'h1);
      cyc();

      // Watchdog: channel 2 streams without last, channel 0 waiting
      drive(3'b101, 3'b000, 1'b1);
      cyc();
      chk("t4_sel", {2'b00, sel_a}, 4'h2);
      for (int i = 0; i < 4; i++) begin
         chk("t4_busy", {3'b000, busy_a}, 4'h1);
         chk("t4_err",  {3'b000, err_a},  4'h0);
         cyc();
      end
      chk("t4_rel_busy", {3'b000, busy_a}, 4'h0);
      chk("t4_rel_err",  {3'b000, err_a},  4'h1);
      cyc();
      chk("t4_err_clr", {3'b000, err_a},  4'h0);
      chk("t4_next",    {2'b00, sel_a},   4'h0);
      chk("t4_nbusy",   {3'b000, busy_a}, 4'h1);
      // Last on the watchdog beat: normal release
      for (int i = 0; i < 3; i++) cyc();
      drive(3'b101, 3'b001, 1'b1);
      cyc();
      chk("t4b_err",  {3'b000, err_a},  4'h0);
      chk("t4b_busy", {3'b000, busy_a}, 4'h0);

      // Reset mid-packet on channel 1
      drive(3'b010, 3'b000, 1'b1);
      cyc();
      chk("t5_sel", {2'b00, sel_a}, 4'h1);
      rst_n = 1'b0;
      cyc();
      chk("t5_busy",  {3'b000, busy_a}, 4'h0);
      chk("t5_sel0",  {2'b00, sel_a},   4'h0);
      chk("t5_valid", {3'b000, vo_a},   4'h0);
      chk("t5_ready", {1'b0, rdy_a},    4'h0);
      chk("t5_err",   {3'b000, err_a},  4'h0);
      rst_n = 1'b1;
      drive(3'b111, 3'b000, 1'b1);
      cyc();
      chk("t5_fresh", {2'b00, sel_a}, 4'h0);
      drive(3'b000, 3'b000, 1'b0);

      // Per-beat arbitration on the LOCK_EN=0 instance
      vb = 3'b101; lb = 3'b000; ri_b = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("t6_sel",   {2'b00, sel_b},   {2'b00, order6[k]});
         chk("t6_busy",  {3'b000, busy_b}, 4'h1);
         chk("t6_valid", {3'b000, vo_b},   4'h1);
         cyc();
         chk("t6_bubble", {3'b000, busy_b}, 4'h0);
         chk("t6_err",    {3'b000, err_b},  4'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
